// File: rtl/rsa_pkg.sv
// rsa_pkg: shared state type, error codes and widths for the RSA phase sequencer
package rsa_pkg;
  localparam int KEY_W = 16;
  localparam int PRIME_W = 8;
  localparam logic [1:0] RSA_OK = 2'd0;
  localparam logic [1:0] RSA_BADOP = 2'd1;
  localparam logic [1:0] RSA_TMO = 2'd2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_GAP1,
    S_ENC,
    S_GAP2,
    S_DEC,
    S_RESP
  } state_t;
  function automatic logic bad_prime(input logic [PRIME_W-1:0] x);
    return x[PRIME_W-1:1] == '0;
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered 0->1 edge detector whose history is reloaded on clr
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic din,
  output logic rise,
  output logic unused_prev
);
  logic prev_q, prev_d;
  // history follows din; the clr cycle is masked so a level already high never counts as an edge
  always_comb begin
    prev_d = din;
    rise = din & ~prev_q & ~clr;
    unused_prev = prev_q;
  end
  // history register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= 1'b0;
    else prev_q <= prev_d;
endmodule

// File: rtl/rsa_phase_sequencer.sv
// rsa_phase_sequencer: drives keygen, encrypt and decrypt phases of the RSA core and returns the results
module rsa_phase_sequencer
  import rsa_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [KEY_W-1:0]   req_m,
  input  logic [PRIME_W-1:0] req_p,
  input  logic [PRIME_W-1:0] req_q,
  output logic [KEY_W-1:0]   rsa_m,
  output logic [PRIME_W-1:0] rsa_p,
  output logic [PRIME_W-1:0] rsa_q,
  output logic               rsa_start,
  output logic               rsa_start1,
  output logic               rsa_start2,
  input  logic               rsa_finish,
  input  logic               rsa_fin1,
  input  logic [KEY_W-1:0]   rsa_n,
  input  logic [KEY_W-1:0]   rsa_d,
  input  logic [KEY_W-1:0]   rsa_rem,
  input  logic [PRIME_W-1:0] rsa_e,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [KEY_W-1:0]   rsp_n,
  output logic [KEY_W-1:0]   rsp_d,
  output logic [PRIME_W-1:0] rsp_e,
  output logic [KEY_W-1:0]   rsp_c,
  output logic [KEY_W-1:0]   rsp_m,
  output logic [1:0]         rsp_err
);
  localparam logic [7:0] TMO_C = 8'(TIMEOUT);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic start_q, start_d, start1_q, start1_d, start2_q, start2_d;
  logic [PRIME_W-1:0] op_p_q, op_p_d, op_q_q, op_q_d, e_q, e_d;
  logic [KEY_W-1:0] op_m_q, op_m_d, n_q, n_d, d_q, d_d, c_q, c_d, pm_q, pm_d;
  logic [1:0] err_q, err_d;
  logic fin_rise, fin1_rise, done, tmo;
  logic fin_prev, fin1_prev;

  rise_detect u_fin (
    .clk(clk),
    .rst_n(rst_n),
    .clr(start_q),
    .din(rsa_finish),
    .rise(fin_rise),
    .unused_prev(fin_prev)
  );

  rise_detect u_fin1 (
    .clk(clk),
    .rst_n(rst_n),
    .clr(start1_q | start2_q),
    .din(rsa_fin1),
    .rise(fin1_rise),
    .unused_prev(fin1_prev)
  );

  // next state, phase pulses, operand latching and result capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    start_d = 1'b0;
    start1_d = 1'b0;
    start2_d = 1'b0;
    op_m_d = op_m_q;
    op_p_d = op_p_q;
    op_q_d = op_q_q;
    n_d = n_q;
    e_d = e_q;
    d_d = d_q;
    c_d = c_q;
    pm_d = pm_q;
    err_d = err_q;
    done = (state_q == S_KEYGEN) ? fin_rise : fin1_rise;
    tmo = cnt_q == TMO_C;
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_m_d = req_m;
        op_p_d = req_p;
        op_q_d = req_q;
        if (bad_prime(req_p) || bad_prime(req_q)) begin
          state_d = S_RESP;
          err_d = RSA_BADOP;
        end else begin
          state_d = S_KEYGEN;
          start_d = 1'b1;
          cnt_d = '0;
        end
      end
      S_KEYGEN, S_ENC, S_DEC: begin
        cnt_d = cnt_q + 8'd1;
        if (done) begin
          cnt_d = '0;
          if (state_q == S_KEYGEN) begin
            n_d = rsa_n;
            e_d = rsa_e;
            d_d = rsa_d;
          end
          if (state_q == S_ENC) c_d = rsa_rem;
          if (state_q == S_DEC) pm_d = rsa_rem;
          state_d = (state_q == S_DEC) ? S_RESP :
                    (state_q == S_KEYGEN) ? ((GAP == 0) ? S_ENC : S_GAP1) :
                    ((GAP == 0) ? S_DEC : S_GAP2);
          start1_d = (state_q == S_KEYGEN) && (GAP == 0);
          start2_d = (state_q == S_ENC) && (GAP == 0);
        end else if (tmo) begin
          cnt_d = '0;
          state_d = S_RESP;
          err_d = RSA_TMO;
        end
      end
      S_GAP1, S_GAP2: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          state_d = (state_q == S_GAP1) ? S_ENC : S_DEC;
          start1_d = state_q == S_GAP1;
          start2_d = state_q == S_GAP2;
        end
      end
      S_RESP: if (rsp_ready) begin
        state_d = S_IDLE;
        n_d = '0;
        e_d = '0;
        d_d = '0;
        c_d = '0;
        pm_d = '0;
        err_d = RSA_OK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counter, pulse and capture registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      start_q <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      op_m_q <= '0;
      op_p_q <= '0;
      op_q_q <= '0;
      n_q <= '0;
      e_q <= '0;
      d_q <= '0;
      c_q <= '0;
      pm_q <= '0;
      err_q <= RSA_OK;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      start_q <= start_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      op_m_q <= op_m_d;
      op_p_q <= op_p_d;
      op_q_q <= op_q_d;
      n_q <= n_d;
      e_q <= e_d;
      d_q <= d_d;
      c_q <= c_d;
      pm_q <= pm_d;
      err_q <= err_d;
    end

  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RESP;
  assign rsa_m = op_m_q;
  assign rsa_p = op_p_q;
  assign rsa_q = op_q_q;
  assign rsa_start = start_q;
  assign rsa_start1 = start1_q;
  assign rsa_start2 = start2_q;
  assign rsp_n = n_q;
  assign rsp_e = e_q;
  assign rsp_d = d_q;
  assign rsp_c = c_q;
  assign rsp_m = pm_q;
  assign rsp_err = err_q;
endmodule

// File: tb/tb_rsa_phase_sequencer.sv
// tb_rsa_phase_sequencer: directed steps against a behavioural RSA core with a response scoreboard
module tb_rsa_phase_sequencer;
  import rsa_pkg::*;
  typedef struct packed {
    logic [15:0] n;
    logic [7:0]  e;
    logic [15:0] d;
    logic [15:0] c;
    logic [15:0] m;
    logic [1:0]  err;
  } rsp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, rsp_ready = 1'b0, hold_fin = 1'b0, mute_fin1 = 1'b0;
  logic fin_q = 1'b0, fin1_q = 1'b0;
  logic [15:0] req_m = '0, rem_q = '0;
  logic [7:0] req_p = '0, req_q = '0;
  logic req_ready, rsa_start, rsa_start1, rsa_start2, rsa_finish, rsa_fin1, rsp_valid;
  logic [15:0] rsa_m, rsp_n, rsp_d, rsp_c, rsp_m;
  logic [7:0] rsa_p, rsa_q, rsp_e;
  logic [1:0] rsp_err;
  rsp_t exp_q[$];
  rsp_t sb_e, good, bad, tmo_exp;
  int errors = 0, checks = 0, cyc = 0;
  int n_start = 0, n_start1 = 0, n_start2 = 0;
  int t_start = 0, t_start1 = 0, t_start2 = 0, t_rsp = 0, t_acc = 0, t_edge = 0;
  logic stable;

  rsa_phase_sequencer #(.TIMEOUT(255), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_m(req_m), .req_p(req_p), .req_q(req_q),
    .rsa_m(rsa_m), .rsa_p(rsa_p), .rsa_q(rsa_q),
    .rsa_start(rsa_start), .rsa_start1(rsa_start1), .rsa_start2(rsa_start2),
    .rsa_finish(rsa_finish), .rsa_fin1(rsa_fin1),
    .rsa_n(16'd3551), .rsa_d(16'd1373), .rsa_rem(rem_q), .rsa_e(8'd5),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_n(rsp_n), .rsp_d(rsp_d), .rsp_e(rsp_e), .rsp_c(rsp_c), .rsp_m(rsp_m),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural core: each done flag is a one-cycle level one cycle after its pulse
  always @(posedge clk) begin
    fin_q <= rsa_start;
    fin1_q <= (rsa_start1 | rsa_start2) & ~mute_fin1;
    if (rsa_start1) rem_q <= 16'h0BEE;
    if (rsa_start2) rem_q <= rsa_m;
  end
  assign rsa_finish = fin_q | hold_fin;
  assign rsa_fin1 = fin1_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // pulse bookkeeping and scoreboard compare on each consumed response
  always @(negedge clk) begin
    if (rsa_start) begin n_start++; t_start = cyc; end
    if (rsa_start1) begin n_start1++; t_start1 = cyc; end
    if (rsa_start2) begin n_start2++; t_start2 = cyc; end
    if (rsp_valid && rsp_ready) begin
      chk("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("rsp_n", 32'(rsp_n), 32'(sb_e.n));
        chk("rsp_e", 32'(rsp_e), 32'(sb_e.e));
        chk("rsp_d", 32'(rsp_d), 32'(sb_e.d));
        chk("rsp_c", 32'(rsp_c), 32'(sb_e.c));
        chk("rsp_m", 32'(rsp_m), 32'(sb_e.m));
        chk("rsp_err", 32'(rsp_err), 32'(sb_e.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    n_start = 0; n_start1 = 0; n_start2 = 0;
  endtask

  task automatic send(input logic [15:0] m, input logic [7:0] p, input logic [7:0] q, input rsp_t e);
    req_m = m; req_p = p; req_q = q; req_valid = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    t_acc = cyc;
    chk("req_ready_at_send", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    t_rsp = cyc;
    chk(tag, 32'(rsp_valid), 1);
  endtask

  task automatic consume();
    tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    good = '{n: 16'd3551, e: 8'd5, d: 16'd1373, c: 16'h0BEE, m: 16'd1256, err: RSA_OK};
    bad = '{n: 16'd0, e: 8'd0, d: 16'd0, c: 16'd0, m: 16'd0, err: RSA_BADOP};
    tmo_exp = '{n: 16'd3551, e: 8'd5, d: 16'd1373, c: 16'd0, m: 16'd0, err: RSA_TMO};
    hold_fin = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_pulses", 32'({rsa_start, rsa_start1, rsa_start2}), 0);
    chk("rst_rsa_m", 32'(rsa_m), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // finish held high from reset: keygen must wait for a fresh edge
    clr_stats();
    send(16'd1256, 8'd67, 8'd53, good);
    repeat (10) tick();
    chk("hold_one_start", 32'(n_start), 1);
    chk("hold_start_at", 32'(t_start), 32'(t_acc + 1));
    chk("hold_no_advance", 32'(n_start1), 0);
    chk("hold_no_rsp", 32'(rsp_valid), 0);
    hold_fin = 1'b0;
    tick();
    hold_fin = 1'b1;
    @(negedge clk);
    t_edge = cyc;
    wait_rsp("hold_rsp_valid", 40);
    chk("hold_start1_at", 32'(t_start1), 32'(t_edge + 3));
    consume();
    hold_fin = 1'b0;
    // nominal run with response stall and a back-to-back bad request
    clr_stats();
    send(16'd1256, 8'd67, 8'd53, good);
    chk("op_m_latched", 32'(rsa_m), 1256);
    chk("op_p_latched", 32'(rsa_p), 67);
    wait_rsp("norm_rsp_valid", 40);
    chk("norm_start_at", 32'(t_start), 32'(t_acc + 1));
    chk("norm_start1_at", 32'(t_start1), 32'(t_acc + 5));
    chk("norm_start2_at", 32'(t_start2), 32'(t_acc + 9));
    chk("norm_rsp_at", 32'(t_rsp), 32'(t_acc + 11));
    chk("norm_pulse_counts", 32'({n_start[3:0], n_start1[3:0], n_start2[3:0]}), 32'h111);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_n != 16'd3551 || rsp_c != 16'h0BEE || rsp_m != 16'd1256 || rsp_err != RSA_OK)
        stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 1);
    tick();
    clr_stats();
    rsp_ready = 1'b1;
    req_m = 16'd99; req_p = 8'd1; req_q = 8'd53; req_valid = 1'b1;
    exp_q.push_back(bad);
    @(negedge clk);
    chk("ready_during_consume", 32'(req_ready), 0);
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("b2b_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("badop_valid_next", 32'(rsp_valid), 1);
    chk("badop_no_pulse", 32'(n_start), 0);
    chk("badop_p_latched", 32'(rsa_p), 1);
    consume();
    // encrypt phase never completes
    clr_stats();
    mute_fin1 = 1'b1;
    send(16'd1256, 8'd67, 8'd53, tmo_exp);
    wait_rsp("tmo_rsp_valid", 400);
    chk("tmo_latency", 32'(t_rsp - t_start1), 256);
    chk("tmo_no_start2", 32'(n_start2), 0);
    consume();
    mute_fin1 = 1'b0;
    // asynchronous reset while start1 is high
    clr_stats();
    send(16'd1256, 8'd67, 8'd53, good);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsa_start1) break;
    end
    chk("arst_saw_start1", 32'(rsa_start1), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start1", 32'(rsa_start1), 0);
    chk("arst_req_ready", 32'(req_ready), 1);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_rsa_m", 32'(rsa_m), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    clr_stats();
    send(16'd1256, 8'd67, 8'd53, good);
    wait_rsp("post_rst_valid", 40);
    chk("post_rst_latency", 32'(t_rsp), 32'(t_acc + 11));
    consume();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
